// File: rtl/relief_dispatcher_n.sv
// relief_dispatcher_n: NUM_RES aging priority queues plus an evacuation FIFO with absolute precedence.
// Optional macro RELIEF_BOOST_STATS_EN enables the saturating Boost_Served_Count statistic.
`default_nettype none

module relief_dispatcher_n #(
  parameter int NUM_RES       = 2,
  parameter int DEPTH         = 4,
  parameter int EVAC_DEPTH    = 4,
  parameter int ZONE_W        = 8,
  parameter int PRI_W         = 2,
  parameter int AGE_W         = 8,
  parameter int AGE_THRESHOLD = 20,
  parameter int CH_W          = $clog2(NUM_RES + 1)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Insert,
  input  logic [CH_W-1:0]    Channel,
  input  logic [ZONE_W-1:0]  Zone,
  input  logic [PRI_W-1:0]   Priority,
  input  logic               Serve,
  output logic               Dispatch_Valid,
  output logic [ZONE_W-1:0]  Dispatch_Zone,
  output logic [PRI_W-1:0]   Dispatch_Priority,
  output logic [CH_W-1:0]    Dispatch_Channel,
  output logic               Dispatch_Boost,
  output logic [NUM_RES-1:0] Queue_Full,
  output logic               Evac_Empty,
  output logic               Evac_Full,
  output logic               Overflow,
  output logic [15:0]        Boost_Served_Count
);

  localparam int SL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EA_W  = (EVAC_DEPTH > 1) ? $clog2(EVAC_DEPTH) : 1;
  localparam int KEY_W = 1 + PRI_W + AGE_W;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_TH  = AGE_W'(AGE_THRESHOLD);
  localparam logic [CH_W-1:0]  EVAC_CH = CH_W'(NUM_RES);

  logic              res_valid [NUM_RES][DEPTH];
  logic [ZONE_W-1:0] res_zone  [NUM_RES][DEPTH];
  logic [PRI_W-1:0]  res_pri   [NUM_RES][DEPTH];
  logic [AGE_W-1:0]  res_age   [NUM_RES][DEPTH];

  logic [ZONE_W-1:0] evac_zone [EVAC_DEPTH];
  logic [PRI_W-1:0]  evac_pri  [EVAC_DEPTH];
  logic [EA_W:0]     wr_ptr;
  logic [EA_W:0]     rd_ptr;
  logic [EA_W-1:0]   wr_idx;
  logic [EA_W-1:0]   rd_idx;

  logic              win_found;
  logic              win_evac;
  logic [CH_W-1:0]   win_ch;
  logic [SL_W-1:0]   win_slot;
  logic [ZONE_W-1:0] win_zone;
  logic [PRI_W-1:0]  win_pri;
  logic              win_boost;
  logic [KEY_W-1:0]  best_key;
  logic [KEY_W-1:0]  cur_key;

  logic              tgt_res;
  logic              tgt_full;
  logic [SL_W-1:0]   tgt_free;
  logic              serve_take;
  logic              evac_pop;
  logic              res_take;
  logic              evac_accept;
  logic              res_accept;
  logic              drop;

  assign wr_idx     = wr_ptr[EA_W-1:0];
  assign rd_idx     = rd_ptr[EA_W-1:0];
  assign Evac_Empty = (wr_ptr == rd_ptr);
  assign Evac_Full  = (wr_ptr[EA_W] != rd_ptr[EA_W]) && (wr_idx == rd_idx);

  always_comb begin
    for (int c = 0; c < NUM_RES; c++) begin
      Queue_Full[c] = 1'b1;
      for (int s = 0; s < DEPTH; s++) begin
        if (!res_valid[c][s]) Queue_Full[c] = 1'b0;
      end
    end
  end

  // Free-slot search uses pre-edge state, so a same-cycle serve never frees room for an insert.
  always_comb begin
    tgt_res  = (Channel < EVAC_CH);
    tgt_full = 1'b1;
    tgt_free = '0;
    for (int c = 0; c < NUM_RES; c++) begin
      if (Channel == CH_W'(c)) begin
        for (int s = DEPTH - 1; s >= 0; s--) begin
          if (!res_valid[c][s]) begin
            tgt_full = 1'b0;
            tgt_free = SL_W'(s);
          end
        end
      end
    end
  end

  // Key ordering {boost, priority, age}; strict compare keeps the lowest channel/slot on ties.
  always_comb begin
    win_found = 1'b0;
    win_evac  = 1'b0;
    win_ch    = '0;
    win_slot  = '0;
    win_zone  = '0;
    win_pri   = '0;
    win_boost = 1'b0;
    best_key  = '0;
    cur_key   = '0;
    if (!Evac_Empty) begin
      win_found = 1'b1;
      win_evac  = 1'b1;
      win_ch    = EVAC_CH;
      win_zone  = evac_zone[rd_idx];
      win_pri   = evac_pri[rd_idx];
    end else begin
      for (int c = 0; c < NUM_RES; c++) begin
        for (int s = 0; s < DEPTH; s++) begin
          cur_key = {(res_age[c][s] >= AGE_TH), res_pri[c][s], res_age[c][s]};
          if (res_valid[c][s] && (!win_found || cur_key > best_key)) begin
            win_found = 1'b1;
            best_key  = cur_key;
            win_ch    = CH_W'(c);
            win_slot  = SL_W'(s);
            win_zone  = res_zone[c][s];
            win_pri   = res_pri[c][s];
            win_boost = cur_key[KEY_W-1];
          end
        end
      end
    end
  end

  assign serve_take  = Serve && win_found;
  assign evac_pop    = serve_take && win_evac;
  assign res_take    = serve_take && !win_evac;
  assign evac_accept = Insert && (Channel == EVAC_CH) && (!Evac_Full || evac_pop);
  assign res_accept  = Insert && tgt_res && !tgt_full;
  assign drop        = Insert && !evac_accept && !res_accept;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < NUM_RES; c++) begin
        for (int s = 0; s < DEPTH; s++) begin
          res_valid[c][s] <= 1'b0;
          res_zone[c][s]  <= '0;
          res_pri[c][s]   <= '0;
          res_age[c][s]   <= '0;
        end
      end
      for (int e = 0; e < EVAC_DEPTH; e++) begin
        evac_zone[e] <= '0;
        evac_pri[e]  <= '0;
      end
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      Dispatch_Valid    <= 1'b0;
      Dispatch_Zone     <= '0;
      Dispatch_Priority <= '0;
      Dispatch_Channel  <= '0;
      Dispatch_Boost    <= 1'b0;
      Overflow          <= 1'b0;
    end else begin
      Overflow <= drop;

      for (int c = 0; c < NUM_RES; c++) begin
        for (int s = 0; s < DEPTH; s++) begin
          if (res_valid[c][s] && res_age[c][s] != AGE_MAX)
            res_age[c][s] <= res_age[c][s] + 1'b1;
          if (evac_accept && res_zone[c][s] == Zone)
            res_valid[c][s] <= 1'b0;
          if (res_take && win_ch == CH_W'(c) && win_slot == SL_W'(s))
            res_valid[c][s] <= 1'b0;
          if (res_accept && Channel == CH_W'(c) && tgt_free == SL_W'(s)) begin
            res_valid[c][s] <= 1'b1;
            res_zone[c][s]  <= Zone;
            res_pri[c][s]   <= Priority;
            res_age[c][s]   <= '0;
          end
        end
      end

      if (evac_accept) begin
        evac_zone[wr_idx] <= Zone;
        evac_pri[wr_idx]  <= Priority;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (evac_pop) rd_ptr <= rd_ptr + 1'b1;

      Dispatch_Valid <= serve_take;
      if (serve_take) begin
        Dispatch_Zone     <= win_zone;
        Dispatch_Priority <= win_pri;
        Dispatch_Channel  <= win_ch;
        Dispatch_Boost    <= win_boost;
      end
    end
  end

`ifdef RELIEF_BOOST_STATS_EN
  logic [15:0] boost_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      boost_cnt <= '0;
    end else if (res_take && win_boost && boost_cnt != 16'hFFFF) begin
      boost_cnt <= boost_cnt + 1'b1;
    end
  end

  assign Boost_Served_Count = boost_cnt;
`else
  assign Boost_Served_Count = 16'd0;
`endif

endmodule

`default_nettype wire
